sram_1r1w_be_pipe: RTL and testbench

- Parametrised successor to the team's 1R1W byte-enable SRAM.
- Generalises byte width, depth and read latency.
- Adds post-reset zero-initialisation sweep, same-address read-during-write forwarding, and a read_valid strobe.
- Used as generic storage for cache tag/data arrays and queues that need a known power-up state.

---
 rtl/sram_pkg.sv | 35 +++
 rtl/sram_1r1w_be_pipe_if.sv | 32 +++
 rtl/sram_be_core.sv | 41 ++++
 rtl/sram_1r1w_be_pipe.sv | 144 ++++++++++++++
 tb/tb_sram_1r1w_be_pipe.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1R1W byte-enable SRAM.
// The lane merge is written against a maximum width so one function serves every configuration.
package sram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int MAX_LANES  = 64;
  localparam int MAX_DATA_W = 512;

  function automatic int calc_data_w(input int nbytes, input int bsz);
    return nbytes * bsz;
  endfunction

  // Bits of lanes selected by mask come from new_w, all other bits keep old_w.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_LANES-1:0]  mask,
    input int                    nbytes,
    input int                    bsz
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_DATA_W; b++) begin
      if ((b < nbytes * bsz) && mask[b / bsz]) begin
        res[b] = new_w[b];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_1r1w_be_pipe_if.sv
// Request/response bundle between a storage client (master) and the SRAM (slave).
// No backpressure: the SRAM accepts one read and one write every cycle once init_busy is low.
interface sram_1r1w_be_pipe_if
  import sram_pkg::*;
#(
  parameter int ADDR_SZ       = 9,
  parameter int DATA_SZ_BYTES = 8,
  parameter int BYTE_SZ       = 8
);
  localparam int DATA_W = calc_data_w(DATA_SZ_BYTES, BYTE_SZ);

  logic                     init_busy;
  logic                     write_en;
  logic [DATA_SZ_BYTES-1:0] write_bytes;
  logic [ADDR_SZ-1:0]       write_addr;
  logic [DATA_W-1:0]        write_data;
  logic                     read_en;
  logic [ADDR_SZ-1:0]       read_addr;
  logic [DATA_W-1:0]        read_data;
  logic                     read_valid;

  modport master (
    input  init_busy, read_data, read_valid,
    output write_en, write_bytes, write_addr, write_data, read_en, read_addr
  );

  modport slave (
    output init_busy, read_data, read_valid,
    input  write_en, write_bytes, write_addr, write_data, read_en, read_addr
  );

endinterface

// File: rtl/sram_be_core.sv
// Raw lane-sliced storage: one write port with per-lane enables, one asynchronous read port.
// Addresses must already be range-checked; only the low index bits are decoded.
module sram_be_core
  import sram_pkg::*;
#(
  parameter int ADDR_SZ       = 9,
  parameter int DATA_SZ_BYTES = 8,
  parameter int BYTE_SZ       = 8,
  parameter int MEM_SZ        = 512
) (
  input  logic                                             clk,
  input  logic                                             i_we,
  input  logic [DATA_SZ_BYTES-1:0]                         i_wbe,
  input  logic [ADDR_SZ-1:0]                               i_waddr,
  input  logic [calc_data_w(DATA_SZ_BYTES, BYTE_SZ)-1:0]   i_wdata,
  input  logic [ADDR_SZ-1:0]                               i_raddr,
  output logic [calc_data_w(DATA_SZ_BYTES, BYTE_SZ)-1:0]   o_rdata
);
  localparam int IDX_W = (MEM_SZ > 1) ? $clog2(MEM_SZ) : 1;

  logic [IDX_W-1:0] w_widx;
  logic [IDX_W-1:0] w_ridx;
  logic             w_unused_addr;

  assign w_widx        = i_waddr[IDX_W-1:0];
  assign w_ridx        = i_raddr[IDX_W-1:0];
  assign w_unused_addr = ^{i_waddr, i_raddr};

  for (genvar g = 0; g < DATA_SZ_BYTES; g++) begin : g_lane
    logic [BYTE_SZ-1:0] r_mem [MEM_SZ];

    always_ff @(posedge clk) begin
      if (i_we && i_wbe[g]) begin
        r_mem[w_widx] <= i_wdata[g*BYTE_SZ +: BYTE_SZ];
      end
    end

    assign o_rdata[g*BYTE_SZ +: BYTE_SZ] = r_mem[w_ridx];
  end

endmodule

// File: rtl/sram_1r1w_be_pipe.sv
// 1R1W byte-enable SRAM with zero-fill after reset, same-address write forwarding and read_valid strobe.
// Read latency 1 + OUT_REG; fully pipelined, never stalls; requests ignored while init_busy is high.
module sram_1r1w_be_pipe
  import sram_pkg::*;
#(
  parameter int ADDR_SZ       = 9,
  parameter int DATA_SZ_BYTES = 8,
  parameter int BYTE_SZ       = 8,
  parameter int MEM_SZ        = 512,
  parameter int OUT_REG       = 0,
  parameter int BYPASS        = 1,
  parameter int INIT_ZERO     = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_1r1w_be_pipe_if.slave bus
);
  localparam int                 DATA_W    = calc_data_w(DATA_SZ_BYTES, BYTE_SZ);
  localparam logic [ADDR_SZ:0]   MEM_LIM   = (ADDR_SZ + 1)'(MEM_SZ);
  localparam logic [ADDR_SZ-1:0] LAST_ADDR = ADDR_SZ'(MEM_SZ - 1);

  state_e             r_state;
  logic [ADDR_SZ-1:0] r_cnt;
  logic               r_busy;
  logic               r_s1_vld;
  logic [DATA_W-1:0]  r_s1_dat;

  logic                     w_sweep;
  logic                     w_ready;
  logic                     w_wr_in_range;
  logic                     w_rd_in_range;
  logic                     w_user_we;
  logic                     w_rd_acc;
  logic                     w_core_we;
  logic [DATA_SZ_BYTES-1:0] w_core_wbe;
  logic [ADDR_SZ-1:0]       w_core_waddr;
  logic [DATA_W-1:0]        w_core_wdata;
  logic [DATA_W-1:0]        w_rdata_raw;
  logic [DATA_SZ_BYTES-1:0] w_byp_mask;
  logic [MAX_DATA_W-1:0]    w_merged_full;
  logic [DATA_W-1:0]        w_rd_word;
  logic                     w_unused_merge_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        INIT: begin
          if ((INIT_ZERO == 0) || (r_cnt == LAST_ADDR)) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_SZ'(1);
          end
        end
        READY: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= INIT;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_sweep       = (r_state == INIT) && !rst && (INIT_ZERO != 0);
  assign w_ready       = (r_state == READY) && !rst;
  assign w_wr_in_range = {1'b0, bus.write_addr} < MEM_LIM;
  assign w_rd_in_range = {1'b0, bus.read_addr} < MEM_LIM;
  assign w_user_we     = w_ready && bus.write_en && w_wr_in_range;
  assign w_rd_acc      = w_ready && bus.read_en;

  // The sweep owns the write port for the whole of INIT, so user writes cannot disturb it.
  assign w_core_we    = w_sweep || w_user_we;
  assign w_core_wbe   = w_sweep ? '1 : bus.write_bytes;
  assign w_core_waddr = w_sweep ? r_cnt : bus.write_addr;
  assign w_core_wdata = w_sweep ? '0 : bus.write_data;

  sram_be_core #(
    .ADDR_SZ       (ADDR_SZ),
    .DATA_SZ_BYTES (DATA_SZ_BYTES),
    .BYTE_SZ       (BYTE_SZ),
    .MEM_SZ        (MEM_SZ)
  ) u_core (
    .clk     (clk),
    .i_we    (w_core_we),
    .i_wbe   (w_core_wbe),
    .i_waddr (w_core_waddr),
    .i_wdata (w_core_wdata),
    .i_raddr (bus.read_addr),
    .o_rdata (w_rdata_raw)
  );

  assign w_byp_mask = ((BYPASS != 0) && w_ready && bus.write_en &&
                       (bus.write_addr == bus.read_addr)) ? bus.write_bytes : '0;

  assign w_merged_full = merge_bytes(MAX_DATA_W'(w_rdata_raw), MAX_DATA_W'(bus.write_data),
                                     MAX_LANES'(w_byp_mask), DATA_SZ_BYTES, BYTE_SZ);
  assign w_unused_merge_hi = ^w_merged_full[MAX_DATA_W-1:DATA_W];
  assign w_rd_word         = w_rd_in_range ? w_merged_full[DATA_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_dat <= '0;
    end else begin
      r_s1_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_dat <= w_rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              r_s2_vld;
    logic [DATA_W-1:0] r_s2_dat;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_vld <= 1'b0;
        r_s2_dat <= '0;
      end else begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_dat <= r_s1_dat;
        end
      end
    end

    assign bus.read_valid = r_s2_vld;
    assign bus.read_data  = r_s2_dat;
  end else begin : g_no_out_reg
    assign bus.read_valid = r_s1_vld;
    assign bus.read_data  = r_s1_dat;
  end

  assign bus.init_busy = r_busy;

endmodule

// File: tb/tb_sram_1r1w_be_pipe.sv
// Bench for sram_1r1w_be_pipe: two instances (OUT_REG=0/BYPASS=1 and OUT_REG=1/BYPASS=0), MEM_SZ=16,
// driven identically; expected reads are queued with their due cycle and matched as outputs appear.
module tb_sram_1r1w_be_pipe;
  localparam int AW = 9;
  localparam int NB = 8;
  localparam int BS = 8;
  localparam int MS = 16;

  typedef struct packed {
    logic [31:0] cyc;
    logic [63:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_1r1w_be_pipe_if #(.ADDR_SZ(AW), .DATA_SZ_BYTES(NB), .BYTE_SZ(BS)) ifa ();
  sram_1r1w_be_pipe_if #(.ADDR_SZ(AW), .DATA_SZ_BYTES(NB), .BYTE_SZ(BS)) ifb ();

  sram_1r1w_be_pipe #(
    .ADDR_SZ(AW), .DATA_SZ_BYTES(NB), .BYTE_SZ(BS), .MEM_SZ(MS),
    .OUT_REG(0), .BYPASS(1), .INIT_ZERO(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  sram_1r1w_be_pipe #(
    .ADDR_SZ(AW), .DATA_SZ_BYTES(NB), .BYTE_SZ(BS), .MEM_SZ(MS),
    .OUT_REG(1), .BYPASS(0), .INIT_ZERO(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   ready    = 1'b0;
  exp_t exp_q [2][$];
  exp_t mon_e;
  logic [63:0] mem [MS];

  logic [1:0]       vld;
  logic [1:0]       busy;
  logic [1:0][63:0] dat;
  assign vld  = {ifb.read_valid, ifa.read_valid};
  assign busy = {ifb.init_busy, ifa.init_busy};
  assign dat  = {ifb.read_data, ifa.read_data};

  // Scoreboard: every valid must match the head entry's cycle and data; overdue entries are misses.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int p = 0; p < 2; p++) begin
      if (vld[p]) begin
        checks++;
        if (exp_q[p].size() == 0) begin
          failures++;
          $display("FAIL sb_spurious dut%0d cyc=%0d got valid data=%h, required no valid", p, cyc, dat[p]);
        end else begin
          mon_e = exp_q[p].pop_front();
          if (mon_e.cyc != 32'(cyc) || mon_e.dat !== dat[p]) begin
            failures++;
            $display("FAIL sb_read dut%0d got cyc=%0d data=%h, required cyc=%0d data=%h",
                     p, cyc, dat[p], mon_e.cyc, mon_e.dat);
          end
        end
      end else if (exp_q[p].size() != 0 && exp_q[p][0].cyc <= 32'(cyc)) begin
        checks++;
        failures++;
        mon_e = exp_q[p].pop_front();
        $display("FAIL sb_missing dut%0d cyc=%0d got no valid, required data=%h at cyc=%0d",
                 p, cyc, mon_e.dat, mon_e.cyc);
      end
    end
  end

  function automatic logic [63:0] rd_model(input int ra, input bit we, input logic [7:0] wb,
                                           input int wa, input logic [63:0] wd, input bit byp);
    logic [63:0] r;
    if (ra >= MS) return 64'h0;
    r = mem[ra];
    if (byp && we && wa == ra) begin
      for (int l = 0; l < NB; l++) if (wb[l]) r[l*8 +: 8] = wd[l*8 +: 8];
    end
    return r;
  endfunction

  task automatic set_req(input bit we, input logic [7:0] wb, input int wa, input logic [63:0] wd,
                         input bit re, input int ra);
    ifa.write_en = we;  ifa.write_bytes = wb;  ifa.write_addr = wa[AW-1:0];
    ifa.write_data = wd; ifa.read_en = re;     ifa.read_addr = ra[AW-1:0];
    ifb.write_en = we;  ifb.write_bytes = wb;  ifb.write_addr = wa[AW-1:0];
    ifb.write_data = wd; ifb.read_en = re;     ifb.read_addr = ra[AW-1:0];
  endtask

  task automatic issue(input bit we, input logic [7:0] wb, input int wa, input logic [63:0] wd,
                       input bit re, input int ra);
    exp_t e;
    @(negedge clk);
    set_req(we, wb, wa, wd, re, ra);
    if (ready) begin
      if (re) begin
        for (int p = 0; p < 2; p++) begin
          e.cyc = 32'(cyc + 1 + p);
          e.dat = rd_model(ra, we, wb, wa, wd, p == 0);
          exp_q[p].push_back(e);
        end
      end
      if (we && wa < MS) begin
        for (int l = 0; l < NB; l++) if (wb[l]) mem[wa][l*8 +: 8] = wd[l*8 +: 8];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 8'h00, 0, 64'h0, 1'b0, 0);
  endtask

  task automatic test_reset;
    int n [2];
    set_req(1'b0, 8'h00, 0, 64'h0, 1'b1, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      checks += 3;
      if (busy[p] !== 1'b1) begin failures++; $display("FAIL reset_busy dut%0d got %b, required 1", p, busy[p]); end
      if (vld[p] !== 1'b0) begin failures++; $display("FAIL reset_valid dut%0d got %b, required 0", p, vld[p]); end
      if (dat[p] !== 64'h0) begin failures++; $display("FAIL reset_data dut%0d got %h, required 0", p, dat[p]); end
    end
    // Requests held active through the sweep must be ignored, including a write to addr 2.
    @(negedge clk);
    set_req(1'b1, 8'hFF, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2);
    rst = 1'b0;
    n[0] = 0; n[1] = 0;
    for (int i = 1; i <= 40 && (n[0] == 0 || n[1] == 0); i++) begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) if (!busy[p] && n[p] == 0) n[p] = i;
      if (n[0] != 0 || n[1] != 0) set_req(1'b0, 8'h00, 0, 64'h0, 1'b0, 0);
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (n[p] != MS) begin failures++; $display("FAIL sweep_len dut%0d got %0d cycles, required %0d", p, n[p], MS); end
    end
    for (int a = 0; a < MS; a++) mem[a] = 64'h0;
    ready = 1'b1;
  endtask

  task automatic check_drained(input string name);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (exp_q[p].size() != 0) begin
        failures++;
        $display("FAIL %s_drain dut%0d got %0d outstanding reads, required 0", name, p, exp_q[p].size());
      end
    end
  endtask

  task automatic test_sweep_zero;
    for (int a = 0; a < MS; a++) issue(1'b0, 8'h00, 0, 64'h0, 1'b1, a);
    idle(4);
    check_drained("sweep_zero");
  endtask

  task automatic test_byte_merge;
    issue(1'b1, 8'hFF, 3, 64'h1122_3344_5566_7788, 1'b0, 0);
    issue(1'b1, 8'h01, 3, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 0);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 3);
    issue(1'b1, 8'h80, 3, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 0);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 3);
    idle(4);
    check_drained("byte_merge");
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (dat[p] !== 64'hBB22_3344_5566_77AA) begin
        failures++;
        $display("FAIL hold_data dut%0d got %h, required %h", p, dat[p], 64'hBB22_3344_5566_77AA);
      end
    end
  endtask

  task automatic test_bypass;
    issue(1'b1, 8'h0F, 5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 5);
    issue(1'b1, 8'h00, 5, 64'h1234_5678_9ABC_DEF0, 1'b1, 5);
    issue(1'b1, 8'hF0, 6, 64'h1234_5678_9ABC_DEF0, 1'b1, 5);
    issue(1'b1, 8'h3C, 6, 64'hCAFE_F00D_DEAD_BEEF, 1'b1, 6);
    idle(4);
    check_drained("bypass");
  endtask

  task automatic test_out_of_range;
    issue(1'b1, 8'hFF, 4, 64'h0404_0404_0404_0404, 1'b0, 0);
    issue(1'b1, 8'hFF, 20, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 20);
    issue(1'b1, 8'hFF, 15, 64'h0F0F_0000_0F0F_0000, 1'b1, 4);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 15);
    issue(1'b1, 8'hFF, 511, 64'h5555_5555_5555_5555, 1'b1, 511);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 15);
    idle(4);
    check_drained("out_of_range");
  endtask

  task automatic test_back_to_back;
    int ra;
    issue(1'b1, 8'hFF, 0, 64'h0000_0000_0000_00A0, 1'b0, 0);
    issue(1'b1, 8'hFF, 1, 64'h0000_0000_0000_00A1, 1'b0, 0);
    issue(1'b1, 8'hFF, 2, 64'h0000_0000_0000_00A2, 1'b0, 0);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 0);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 1);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 2);
    for (int i = 0; i < 80; i++) begin
      int wa;
      wa = $urandom_range(0, 19);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 19);
      issue(1'($urandom_range(0, 1)), 8'($urandom), wa, {$urandom, $urandom},
            1'($urandom_range(0, 1)), ra);
    end
    idle(4);
    check_drained("back_to_back");
  endtask

  task automatic test_mid_reset;
    int n [2];
    issue(1'b1, 8'hFF, 1, 64'h0101_0101_0101_0101, 1'b0, 0);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 1);
    // The OUT_REG=1 instance is still holding this read when reset lands, so it must never appear.
    void'(exp_q[1].pop_back());
    @(negedge clk);
    set_req(1'b0, 8'h00, 0, 64'h0, 1'b0, 0);
    rst   = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      checks += 3;
      if (vld[p] !== 1'b0) begin failures++; $display("FAIL midrst_valid dut%0d got %b, required 0", p, vld[p]); end
      if (dat[p] !== 64'h0) begin failures++; $display("FAIL midrst_data dut%0d got %h, required 0", p, dat[p]); end
      if (busy[p] !== 1'b1) begin failures++; $display("FAIL midrst_busy dut%0d got %b, required 1", p, busy[p]); end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n[0] = 0; n[1] = 0;
    for (int i = 1; i <= 40 && (n[0] == 0 || n[1] == 0); i++) begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) if (!busy[p] && n[p] == 0) n[p] = i;
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (n[p] != MS) begin failures++; $display("FAIL resweep_len dut%0d got %0d cycles, required %0d", p, n[p], MS); end
    end
    for (int a = 0; a < MS; a++) mem[a] = 64'h0;
    ready = 1'b1;
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 1);
    issue(1'b0, 8'h00, 0, 64'h0, 1'b1, 3);
    idle(4);
    check_drained("mid_reset");
  endtask

  initial begin
    test_reset();
    test_sweep_zero();
    test_byte_merge();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
